// File: rtl/fetch_pkg.sv
// Shared types and constants for the operand-fetch stage and its shifter.
package fetch_pkg;
  localparam int WIDTH_DEF = 16;
  localparam int NREGS_DEF = 8;
  localparam int RSEL_DEF  = 3;

  typedef enum logic [1:0] {IDLE, RD_A, RD_B, VALID} state_t;

  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_LSL  = 2'b01;
  localparam logic [1:0] SH_LSR  = 2'b10;
  localparam logic [1:0] SH_ASR  = 2'b11;
endpackage

// File: rtl/operand_shifter.sv
// Combinational one-bit shifter for the B operand: none, LSL1, LSR1 or ASR1.
module operand_shifter
  import fetch_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] x_i,
  input  logic [1:0]       sh_i,
  output logic [WIDTH-1:0] y_o
);

  always_comb begin
    y_o = x_i;
    unique case (sh_i)
      SH_NONE: y_o = x_i;
      SH_LSL:  y_o = {x_i[WIDTH-2:0], 1'b0};
      SH_LSR:  y_o = {1'b0, x_i[WIDTH-1:1]};
      SH_ASR:  y_o = {x_i[WIDTH-1], x_i[WIDTH-1:1]};
    endcase
  end

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: register file plus IDLE/RD_A/RD_B/VALID read sequencer.
// Define FETCH_BYPASS_EN to forward a same-cycle write into the captured operand.
module operand_fetch
  import fetch_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int RSEL  = RSEL_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [RSEL-1:0]  readnum_a,
  input  logic [RSEL-1:0]  readnum_b,
  input  logic [1:0]       shift,
  input  logic             write,
  input  logic [RSEL-1:0]  writenum,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Ain,
  output logic [WIDTH-1:0] Bin
);

  logic [WIDTH-1:0] regs_q [NREGS];
  state_t           state_q;
  logic [RSEL-1:0]  a_idx_q, b_idx_q;
  logic [1:0]       sh_q;
  logic [WIDTH-1:0] ain_q, bin_q;
  logic             valid_q, busy_q;

  logic [WIDTH-1:0] rd_a_d, rd_b_d, b_shift_d;

  always_comb begin
    rd_a_d = regs_q[a_idx_q];
    rd_b_d = regs_q[b_idx_q];
`ifdef FETCH_BYPASS_EN
    if (write && (writenum == a_idx_q)) rd_a_d = data_in;
    if (write && (writenum == b_idx_q)) rd_b_d = data_in;
`endif
  end

  operand_shifter #(.WIDTH(WIDTH)) u_shifter (
    .x_i  (rd_b_d),
    .sh_i (sh_q),
    .y_o  (b_shift_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_idx_q <= '0;
      b_idx_q <= '0;
      sh_q    <= SH_NONE;
      ain_q   <= '0;
      bin_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      // Writeback runs independently of the read sequencer.
      if (write) regs_q[writenum] <= data_in;
      unique case (state_q)
        IDLE: if (start) begin
          a_idx_q <= readnum_a;
          b_idx_q <= readnum_b;
          sh_q    <= shift;
          busy_q  <= 1'b1;
          state_q <= RD_A;
        end
        RD_A: begin
          ain_q   <= rd_a_d;
          state_q <= RD_B;
        end
        RD_B: begin
          bin_q   <= b_shift_d;
          valid_q <= 1'b1;
          state_q <= VALID;
        end
        VALID: if (out_ready) begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign out_valid = valid_q;
  assign Ain       = ain_q;
  assign Bin       = bin_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard bench for operand_fetch: stimulus queues expected {Ain,Bin}, a monitor checks handshakes.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  readnum_a = '0, readnum_b = '0, writenum = '0;
  logic [1:0]  shift = '0;
  logic        write = 1'b0;
  logic [15:0] data_in = '0;
  logic        busy, out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] Ain, Bin;

  int errors = 0;
  int checks = 0;
  logic [31:0] sb_q[$];

  operand_fetch dut (
    .clk(clk), .reset(reset), .start(start),
    .readnum_a(readnum_a), .readnum_b(readnum_b), .shift(shift),
    .write(write), .writenum(writenum), .data_in(data_in),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .Ain(Ain), .Bin(Bin)
  );

  always #5 clk = ~clk;

  // Monitor: every accepted handshake must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      logic [31:0] exp_v;
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got Ain=%h Bin=%h, no transaction expected", Ain, Bin);
      end else begin
        exp_v = sb_q.pop_front();
        if ({Ain, Bin} !== exp_v) begin
          errors++;
          $display("FAIL sb_data: got Ain=%h Bin=%h, expected Ain=%h Bin=%h",
                   Ain, Bin, exp_v[31:16], exp_v[15:0]);
        end else
          $display("txn ok: Ain=%h Bin=%h", Ain, Bin);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp_v);
    end
  endtask

  task automatic wr(input logic [2:0] idx, input logic [15:0] val);
    write = 1'b1; writenum = idx; data_in = val;
    tick();
    write = 1'b0;
    $display("write R%0d=%h", idx, val);
  endtask

  task automatic fetch(input logic [2:0] a, input logic [2:0] b, input logic [1:0] sh,
                       input logic [15:0] ea, input logic [15:0] eb);
    chk("pre_idle_busy", busy, 0);
    readnum_a = a; readnum_b = b; shift = sh; start = 1'b1; out_ready = 1'b1;
    sb_q.push_back({ea, eb});
    tick();
    start = 1'b0; readnum_a = ~a; readnum_b = ~b; shift = ~sh;
    chk("rda_busy", busy, 1);
    chk("rda_valid", out_valid, 0);
    tick();
    chk("rdb_valid", out_valid, 0);
    tick();
    chk("latency_valid", out_valid, 1);
    tick();
    chk("post_valid", out_valid, 0);
    chk("post_busy", busy, 0);
  endtask

  initial begin
    logic [15:0] exp_b;
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_ain", Ain, 0);
    chk("rst_bin", Bin, 0);

    wr(3'd3, 16'h1234);
    wr(3'd5, 16'h0002);
    fetch(3'd3, 3'd5, 2'b00, 16'h1234, 16'h0002);

    wr(3'd1, 16'h8001);
    fetch(3'd1, 3'd1, 2'b01, 16'h8001, 16'h0002);
    fetch(3'd1, 3'd1, 2'b10, 16'h8001, 16'h4000);
    fetch(3'd1, 3'd1, 2'b11, 16'h8001, 16'hC000);

    // Backpressure: hold VALID, poke start and indices, then release.
    readnum_a = 3'd1; readnum_b = 3'd5; shift = 2'b00; start = 1'b1; out_ready = 1'b0;
    sb_q.push_back({16'h8001, 16'h0002});
    tick();
    start = 1'b0;
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      start = i[0]; readnum_a = 3'(i);
      tick();
      chk("hold_valid", out_valid, 1);
      chk("hold_ain", Ain, 16'h8001);
      chk("hold_bin", Bin, 16'h0002);
    end
    start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    chk("release_valid", out_valid, 0);
    chk("release_busy", busy, 0);
    tick();
    chk("start_ignored_busy", busy, 0);

    // Same-cycle write to the B register during RD_B.
    wr(3'd2, 16'h0011);
`ifdef FETCH_BYPASS_EN
    exp_b = 16'hBEEF;
`else
    exp_b = 16'h0011;
`endif
    readnum_a = 3'd3; readnum_b = 3'd2; shift = 2'b00; start = 1'b1;
    sb_q.push_back({16'h1234, exp_b});
    tick();
    start = 1'b0;
    tick();
    write = 1'b1; writenum = 3'd2; data_in = 16'hBEEF;
    tick();
    write = 1'b0;
    chk("bypass_valid", out_valid, 1);
    tick();
    fetch(3'd2, 3'd2, 2'b00, 16'hBEEF, 16'hBEEF);

    // Back-to-back with start held: one fetch per 4 cycles.
    readnum_a = 3'd3; readnum_b = 3'd5; shift = 2'b00; start = 1'b1; out_ready = 1'b1;
    repeat (3) sb_q.push_back({16'h1234, 16'h0002});
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk($sformatf("b2b_busy_%0d", k), busy, ((k % 4) != 0) ? 1 : 0);
    end
    start = 1'b0;
    tick();
    chk("b2b_end_busy", busy, 0);
    chk("b2b_sb_drained", sb_q.size(), 0);

    // Reset during RD_B, with a write in the reset cycle that must be dropped.
    readnum_a = 3'd3; readnum_b = 3'd5; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    reset = 1'b1; write = 1'b1; writenum = 3'd7; data_in = 16'hFFFF;
    tick();
    reset = 1'b0; write = 1'b0;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ain", Ain, 0);
    chk("mid_rst_bin", Bin, 0);
    fetch(3'd3, 3'd5, 2'b00, 16'h0000, 16'h0000);
    fetch(3'd7, 3'd1, 2'b00, 16'h0000, 16'h0000);

    tick();
    chk("sb_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1);
  end

endmodule
